// File: rtl/conv_window_feeder_if.sv
// Frame-RAM read port plus framed pixel stream toward the convolver.
interface conv_window_feeder_if #(
    parameter int unsigned PIXEL_NB = 7,
    parameter int unsigned ADDR_NB  = 6
);
    logic [ADDR_NB-1:0]  o_rd_addr;
    logic                o_rd_en;
    logic [PIXEL_NB-1:0] i_rd_data;
    logic [PIXEL_NB-1:0] o_pixel;
    logic                o_pixel_valid;
    logic                o_win_first;
    logic                o_win_last;
    logic                o_frame_last;

    // Feeder side: issues reads, receives RAM data, drives the stream.
    modport master (
        output o_rd_addr, o_rd_en,
        input  i_rd_data,
        output o_pixel, o_pixel_valid, o_win_first, o_win_last, o_frame_last
    );

    // RAM / convolver side.
    modport slave (
        input  o_rd_addr, o_rd_en,
        output i_rd_data,
        input  o_pixel, o_pixel_valid, o_win_first, o_win_last, o_frame_last
    );
endinterface

// File: rtl/conv_window_feeder.sv
// Walks every KxK window of a stored image (row-major windows, row-major
// patch) and streams the pixels to the convolver, one per cycle, no gaps.
module conv_window_feeder #(
    parameter int unsigned PIXEL_NB    = 7,
    parameter int unsigned KERNEL_SIZE = 3,
    parameter int unsigned IMG_W       = 8,
    parameter int unsigned IMG_H       = 8,
    parameter int unsigned ADDR_NB     = 6
) (
    input  logic                  clk100,
    input  logic                  in_reset,
    input  logic                  i_start,
    conv_window_feeder_if.master  bus,
    output logic                  o_busy,
    output logic                  o_done
);
    localparam int unsigned CW = $clog2(((IMG_W > IMG_H) ? IMG_W : IMG_H) + 1);

    localparam logic [CW-1:0]      K_MAX   = CW'(KERNEL_SIZE - 1);
    localparam logic [CW-1:0]      COL_MAX = CW'(IMG_W - KERNEL_SIZE);
    localparam logic [CW-1:0]      ROW_MAX = CW'(IMG_H - KERNEL_SIZE);
    localparam logic [CW-1:0]      C_ONE   = CW'(1);
    localparam logic [ADDR_NB-1:0] A_ONE   = ADDR_NB'(1);
    localparam logic [ADDR_NB-1:0] W_STEP  = ADDR_NB'(IMG_W);
    localparam logic [ADDR_NB-1:0] K_STEP  = ADDR_NB'(KERNEL_SIZE);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       kx_q, kx_d, ky_q, ky_d, col_q, col_d, row_q, row_d;
    logic [ADDR_NB-1:0]  addr_q, addr_d;   // current read address
    logic [ADDR_NB-1:0]  line_q, line_d;   // address of (row+ky, col)
    logic [ADDR_NB-1:0]  win_q, win_d;     // address of (row, col)
    logic                rd_en_q, rd_en_d;
    logic                drain_q, drain_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                first_c, wlast_c, flast_c;

    // Pipeline stage aligned with i_rd_data, then the output stage.
    logic                v1_q, first1_q, wlast1_q, flast1_q;
    logic [PIXEL_NB-1:0] pixel_q;
    logic                valid_q, first_q, wlast_q, flast_q;

    // Position tags of the address being issued this cycle.
    assign first_c = (kx_q == '0) && (ky_q == '0);
    assign wlast_c = (kx_q == K_MAX) && (ky_q == K_MAX);
    assign flast_c = wlast_c && (col_q == COL_MAX) && (row_q == ROW_MAX);

    // Next-state, counter stepping and incremental address generation.
    always_comb begin
        state_d = state_q;
        kx_d    = kx_q;
        ky_d    = ky_q;
        col_d   = col_q;
        row_d   = row_q;
        addr_d  = addr_q;
        line_d  = line_q;
        win_d   = win_q;
        rd_en_d = 1'b0;
        drain_d = drain_q;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d = S_RUN;
                    kx_d    = '0;
                    ky_d    = '0;
                    col_d   = '0;
                    row_d   = '0;
                    addr_d  = '0;
                    line_d  = '0;
                    win_d   = '0;
                    rd_en_d = 1'b1;
                end
            end
            S_RUN: begin
                if (kx_q != K_MAX) begin
                    kx_d    = kx_q + C_ONE;
                    addr_d  = addr_q + A_ONE;
                    rd_en_d = 1'b1;
                end else if (ky_q != K_MAX) begin
                    kx_d    = '0;
                    ky_d    = ky_q + C_ONE;
                    line_d  = line_q + W_STEP;
                    addr_d  = line_q + W_STEP;
                    rd_en_d = 1'b1;
                end else if (col_q != COL_MAX) begin
                    kx_d    = '0;
                    ky_d    = '0;
                    col_d   = col_q + C_ONE;
                    win_d   = win_q + A_ONE;
                    line_d  = win_q + A_ONE;
                    addr_d  = win_q + A_ONE;
                    rd_en_d = 1'b1;
                end else if (row_q != ROW_MAX) begin
                    // Last column window base + K lands on the next row start.
                    kx_d    = '0;
                    ky_d    = '0;
                    col_d   = '0;
                    row_d   = row_q + C_ONE;
                    win_d   = win_q + K_STEP;
                    line_d  = win_q + K_STEP;
                    addr_d  = win_q + K_STEP;
                    rd_en_d = 1'b1;
                end else begin
                    state_d = S_DRAIN;
                    drain_d = 1'b0;
                end
            end
            S_DRAIN: begin
                if (drain_q) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // FSM, counter and address registers.
    always_ff @(posedge clk100) begin
        if (in_reset) begin
            state_q <= S_IDLE;
            kx_q    <= '0;
            ky_q    <= '0;
            col_q   <= '0;
            row_q   <= '0;
            addr_q  <= '0;
            line_q  <= '0;
            win_q   <= '0;
            rd_en_q <= 1'b0;
            drain_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            kx_q    <= kx_d;
            ky_q    <= ky_d;
            col_q   <= col_d;
            row_q   <= row_d;
            addr_q  <= addr_d;
            line_q  <= line_d;
            win_q   <= win_d;
            rd_en_q <= rd_en_d;
            drain_q <= drain_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Two-stage tag shift alongside the RAM read; pixel holds when idle.
    always_ff @(posedge clk100) begin
        if (in_reset) begin
            v1_q     <= 1'b0;
            first1_q <= 1'b0;
            wlast1_q <= 1'b0;
            flast1_q <= 1'b0;
            pixel_q  <= '0;
            valid_q  <= 1'b0;
            first_q  <= 1'b0;
            wlast_q  <= 1'b0;
            flast_q  <= 1'b0;
        end else begin
            v1_q     <= rd_en_q;
            first1_q <= rd_en_q & first_c;
            wlast1_q <= rd_en_q & wlast_c;
            flast1_q <= rd_en_q & flast_c;
            if (v1_q) begin
                pixel_q <= bus.i_rd_data;
            end
            valid_q  <= v1_q;
            first_q  <= first1_q;
            wlast_q  <= wlast1_q;
            flast_q  <= flast1_q;
        end
    end

    assign bus.o_rd_addr     = addr_q;
    assign bus.o_rd_en       = rd_en_q;
    assign bus.o_pixel       = pixel_q;
    assign bus.o_pixel_valid = valid_q;
    assign bus.o_win_first   = first_q;
    assign bus.o_win_last    = wlast_q;
    assign bus.o_frame_last  = flast_q;
    assign o_busy            = busy_q;
    assign o_done            = done_q;
endmodule

// File: tb/tb_conv_window_feeder.sv
// Bench for conv_window_feeder: RAM model, window reference model,
// scoreboard queue with an independent monitor, plus a 3x3 image build.
module tb_conv_window_feeder;
    localparam int unsigned PIXEL_NB = 7;
    localparam int unsigned K        = 3;
    localparam int unsigned IMG_W    = 8;
    localparam int unsigned IMG_H    = 8;
    localparam int unsigned ADDR_NB  = 6;
    localparam int unsigned NPIX     = K * K * (IMG_H - K + 1) * (IMG_W - K + 1);

    typedef struct packed {
        logic [PIXEL_NB-1:0] pix;
        logic                first;
        logic                wlast;
        logic                flast;
    } exp_t;

    logic clk100 = 1'b0;
    always #5 clk100 = ~clk100;

    logic in_reset, i_start, o_busy, o_done;
    logic s_start, s_busy, s_done;

    conv_window_feeder_if #(.PIXEL_NB(PIXEL_NB), .ADDR_NB(ADDR_NB)) bus ();
    conv_window_feeder_if #(.PIXEL_NB(PIXEL_NB), .ADDR_NB(4))       sbus ();

    conv_window_feeder #(
        .PIXEL_NB(PIXEL_NB), .KERNEL_SIZE(K), .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_NB(ADDR_NB)
    ) dut (
        .clk100(clk100), .in_reset(in_reset), .i_start(i_start),
        .bus(bus), .o_busy(o_busy), .o_done(o_done)
    );

    conv_window_feeder #(
        .PIXEL_NB(PIXEL_NB), .KERNEL_SIZE(3), .IMG_W(3), .IMG_H(3), .ADDR_NB(4)
    ) dut_small (
        .clk100(clk100), .in_reset(in_reset), .i_start(s_start),
        .bus(sbus), .o_busy(s_busy), .o_done(s_done)
    );

    // Synchronous single-port frame RAMs.
    logic [PIXEL_NB-1:0] mem [0:(1<<ADDR_NB)-1];
    always @(posedge clk100) if (bus.o_rd_en) bus.i_rd_data <= mem[bus.o_rd_addr];
    always @(posedge clk100) if (sbus.o_rd_en) sbus.i_rd_data <= PIXEL_NB'(sbus.o_rd_addr);

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   exp_done = 1'b0;

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, got, want);
        end
    endtask

    // Reference model: enumerate windows and patch pixels straight from the image.
    task automatic build_expected();
        for (int row = 0; row <= int'(IMG_H - K); row++)
            for (int col = 0; col <= int'(IMG_W - K); col++)
                for (int ky = 0; ky < int'(K); ky++)
                    for (int kx = 0; kx < int'(K); kx++) begin
                        exp_t e;
                        e.pix   = mem[(row + ky) * IMG_W + col + kx];
                        e.first = (kx == 0) && (ky == 0);
                        e.wlast = (kx == int'(K) - 1) && (ky == int'(K) - 1);
                        e.flast = e.wlast && (row == int'(IMG_H - K)) && (col == int'(IMG_W - K));
                        exp_q.push_back(e);
                    end
    endtask

    // Monitor: pops the scoreboard on every valid pixel; done must follow frame_last.
    always @(negedge clk100) begin
        if (in_reset) begin
            exp_done = 1'b0;
        end else begin
            if (bus.o_pixel_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL pixel_stream got pix=%0d with no pixel expected", bus.o_pixel);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (bus.o_pixel !== e.pix || bus.o_win_first !== e.first ||
                        bus.o_win_last !== e.wlast || bus.o_frame_last !== e.flast) begin
                        failures++;
                        $display("FAIL pixel_stream got pix=%0d f=%0b l=%0b fl=%0b expected pix=%0d f=%0b l=%0b fl=%0b",
                                 bus.o_pixel, bus.o_win_first, bus.o_win_last, bus.o_frame_last,
                                 e.pix, e.first, e.wlast, e.flast);
                    end
                end
            end
            if (exp_done) begin
                checks++;
                if (o_done !== 1'b1) begin
                    failures++;
                    $display("FAIL done_after_last got=%0b expected=1", o_done);
                end
            end else if (o_done) begin
                checks++;
                failures++;
                $display("FAIL spurious_done got=1 expected=0");
            end
            exp_done = bus.o_pixel_valid && bus.o_frame_last;
        end
    end

    // One frame; called just after a negedge, returns at the first IDLE cycle's negedge.
    task automatic run_frame(input bit disturb, input bit directed);
        int cyc = 0, nvalid = 0, first_v = -1, last_v = -1, sum = 0;
        bit got_done = 1'b0;
        logic [PIXEL_NB-1:0] cap [NPIX];
        build_expected();
        i_start = 1'b1;
        while (!got_done && cyc < 2000) begin
            @(negedge clk100);
            cyc++;
            i_start = disturb && (cyc == 50 || cyc == 51 || cyc == 200);
            if (cyc == 1) begin
                chk("busy_first_run", o_busy, 1);
                chk("rd_en_first_run", bus.o_rd_en, 1);
                chk("rd_addr_first_run", bus.o_rd_addr, 0);
            end
            if (bus.o_pixel_valid) begin
                if (nvalid < int'(NPIX)) cap[nvalid] = bus.o_pixel;
                if (nvalid < 9) sum += int'(bus.o_pixel);
                nvalid++;
                if (first_v < 0) first_v = cyc;
                last_v = cyc;
            end
            if (o_done) begin
                got_done = 1'b1;
                chk("busy_in_done", o_busy, 1);
            end
        end
        chk("done_seen", got_done, 1);
        chk("first_valid_latency", first_v, 3);
        chk("valid_count", nvalid, NPIX);
        chk("valid_contiguous", last_v - first_v + 1, NPIX);
        chk("done_cycle", cyc, last_v + 1);
        if (directed) begin
            chk("first_window_sum", sum, 81);
            chk("pix0", cap[0], 0);
            chk("pix8", cap[8], 18);
            chk("pix9", cap[9], 1);
            chk("win_r0c5_first", cap[45], 5);
            chk("win_r0c5_last", cap[53], 23);
            chk("win_r1c0_first", cap[54], 8);
            chk("pix_last", cap[NPIX-1], 63);
        end
        i_start = disturb;
        @(negedge clk100);
        i_start = 1'b0;
        chk("done_one_cycle", o_done, 0);
        chk("busy_after_done", o_busy, 0);
        chk("rd_en_after_done", bus.o_rd_en, 0);
        chk("scoreboard_empty", exp_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int nvalid, cnt, sidx, slast, sdone;
        in_reset = 1'b1;
        i_start  = 1'b0;
        s_start  = 1'b0;
        for (int a = 0; a < (1 << ADDR_NB); a++) mem[a] = PIXEL_NB'(a);
        repeat (3) @(posedge clk100);
        @(negedge clk100);
        chk("rst_valid", bus.o_pixel_valid, 0);
        chk("rst_pixel", bus.o_pixel, 0);
        chk("rst_flags", {bus.o_win_first, bus.o_win_last, bus.o_frame_last}, 0);
        chk("rst_rd", {bus.o_rd_en, bus.o_rd_addr}, 0);
        chk("rst_busy_done", {o_busy, o_done}, 0);
        in_reset = 1'b0;
        @(negedge clk100);

        // Degenerate 3x3 image: one window, tags coincide on pixel 8.
        s_start = 1'b1;
        sidx = 0; slast = -1; sdone = -1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk100);
            s_start = 1'b0;
            if (sbus.o_pixel_valid) begin
                chk("small_pix", sbus.o_pixel, sidx);
                chk("small_first", sbus.o_win_first, int'(sidx == 0));
                chk("small_last", sbus.o_win_last, int'(sidx == 8));
                chk("small_flast", sbus.o_frame_last, int'(sidx == 8));
                if (sidx == 8) slast = c;
                sidx++;
            end
            if (s_done) sdone = c;
        end
        chk("small_count", sidx, 9);
        chk("small_done", sdone, slast + 1);

        // Identity image, undisturbed.
        run_frame(1'b0, 1'b1);
        // Random images with ignored start pulses; the second starts right after DONE.
        for (int a = 0; a < (1 << ADDR_NB); a++) mem[a] = PIXEL_NB'($urandom_range(0, 127));
        run_frame(1'b1, 1'b0);
        for (int a = 0; a < (1 << ADDR_NB); a++) mem[a] = PIXEL_NB'($urandom_range(0, 127));
        run_frame(1'b1, 1'b0);

        // Reset at pixel 100 aborts the frame.
        for (int a = 0; a < (1 << ADDR_NB); a++) mem[a] = PIXEL_NB'(a);
        build_expected();
        i_start = 1'b1;
        nvalid = 0;
        for (int c = 1; c < 400 && nvalid < 100; c++) begin
            @(negedge clk100);
            i_start = 1'b0;
            if (bus.o_pixel_valid) nvalid++;
        end
        chk("reached_pixel_100", nvalid, 100);
        in_reset = 1'b1;
        @(negedge clk100);
        chk("abort_valid", bus.o_pixel_valid, 0);
        chk("abort_busy", o_busy, 0);
        chk("abort_rd_en", bus.o_rd_en, 0);
        chk("abort_done", o_done, 0);
        @(negedge clk100);
        in_reset = 1'b0;
        exp_q.delete();
        cnt = 0;
        repeat (10) begin
            @(negedge clk100);
            if (bus.o_pixel_valid || o_done || o_busy) cnt++;
        end
        chk("idle_after_abort", cnt, 0);
        run_frame(1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
